uart_vector_harness: RTL
========================

// Module: uart_vector_harness
// PURPOSE
//  Parametrised UART test-vector harness between a byte UART (rx/tx strobes) and a circuit-under-test (CUT).
//  Collects IN_BITS ASCII '0'/'1' chars into a vector, applies it to the CUT, waits SETTLE cycles, samples the
//  CUT output and replies "=" + OUT_BITS chars + "#". Adds optional echo, whitespace skipping, invalid-char
//  recovery, a one-entry rx hold buffer and frame/error counters. The CUT wrapper slices cut_in into its pins.
// PARAMETERS
//  IN_BITS   11  CUT input vector width (1..255 chars per frame)
//  OUT_BITS  8   CUT output vector width (1..255 chars per reply)
//  ECHO      1   1: echo each accepted '0'/'1' char; 0: no echo
//  SETTLE    4   cycles from cut_strobe to the cut_out sample (>=1)
// PORTS
//  clk        in   1         system clock, rising edge
//  rst        in   1         asynchronous active-high reset
//  rx_data    in   8         received byte, valid when rx_ready=1
//  rx_ready   in   1         one-cycle strobe per received byte
//  tx_ready   in   1         1 = transmitter idle; drops while a byte is sent
//  tx_start   out  1         one-cycle pulse: send tx_data
//  tx_data    out  8         byte to transmit, stable from tx_start until tx_ready falls
//  cut_in     out  IN_BITS   applied vector; first char received -> MSB
//  cut_out    in   OUT_BITS  CUT response
//  cut_strobe out  1         one-cycle pulse in the first cycle cut_in holds a new vector
//  frame_cnt  out  16        completed frames (wraps 16'hFFFF->0)
//  err_cnt    out  8         invalid chars + dropped bytes, saturates at 8'hFF
// BEHAVIOUR
//  Reset (async, any state): tx_start=0, tx_data=0, cut_in=0, cut_strobe=0, counters=0, bit index=0,
//   hold buffer empty, state=RX. Partial frames and pending replies are discarded.
//  Char classes: '0'(0x30)/'1'(0x31)=bit; 0x20/0x0D/0x0A=whitespace (ignored, never echoed); other=invalid.
//  Hold buffer: rx_ready outside RX stores the byte if empty; if full the new byte is dropped, err_cnt++.
//   On entering RX with the buffer full, the held byte is consumed first, exactly like an rx_ready in RX.
//   rx_ready in the same cycle the held byte is consumed goes into the buffer (no drop).
//  Tx handshake (every send): SEND waits tx_ready=1, pulses tx_start for 1 cycle with tx_data,
//   then BUSY waits tx_ready=0 before the next state. tx_start never asserts while tx_ready=0.
//  States:
//   RX      bit: shift into shreg, idx++; ECHO=1 -> ECHO_SEND(tx_data=char); ECHO=0 and idx reached
//           IN_BITS -> APPLY; else stay. Whitespace: stay. Invalid: idx=0, shreg cleared, -> ERR_SEND.
//   ECHO_SEND/ECHO_BUSY  send echo; then APPLY if frame complete, else RX.
//   APPLY   cut_in<=shreg, cut_strobe=1, idx=0, settle counter=SETTLE-1 -> SETTLE.
//   SETTLE  counts down; at 0 cap<=cut_out -> EQ_SEND. cut_out sampled exactly SETTLE cycles after cut_strobe.
//   EQ_SEND/EQ_BUSY  send '=' (0x3D).
//   BIT_SEND/BIT_BUSY  send cap MSB first as '0'/'1', OUT_BITS times.
//   HASH_SEND/HASH_BUSY  send '#' (0x23); frame_cnt++ as the '#' tx_start issues; -> RX.
//   ERR_SEND/ERR_BUSY  send '?' (0x3F); err_cnt++ (saturating) as the '?' tx_start issues; -> RX.
//  Latency, ECHO=0, tx_ready held 1: final rx_ready at edge T -> cut_strobe at T+1 -> sample at T+1+SETTLE
//   -> '=' tx_start the next cycle.
//  cut_in holds its value between frames and is unchanged by invalid chars or dropped bytes.
//  The error-increment and drop-increment in one cycle count as two, saturating at 0xFF.
// TESTING
//  1 IN_BITS=11,OUT_BITS=8,ECHO=1: send "10110000101", CUT echoes cut_in[7:0] -> echo of 11 chars,
//    cut_in=11'h585, cut_strobe once, reply "=10000101#", frame_cnt=1.
//  2 ECHO=0,SETTLE=4: track the final rx_ready at edge T -> cut_strobe at T+1, cut_out sampled at T+5;
//    change cut_out at T+6 -> no effect on the reply.
//  3 Send "1 0\r\n1..." with spaces/CRLF interleaved -> identical cut_in and reply to the no-whitespace frame, no echo of whitespace.
//  4 Send "101x" -> '?' sent, err_cnt=1, cut_in unchanged; the next full 11-char frame is applied correctly.
//  5 Hold tx_ready=0 during the reply and fire 2 rx bytes -> first byte held and used after '#', second dropped, err_cnt+1.
//  6 Assert rst mid-reply (after '=') -> outputs return to reset values immediately; no further tx_start; the next frame works.

Source files
------------

// File: rtl/uart_vector_harness.sv
// UART test-vector harness: gathers '0'/'1' chars into a CUT input vector, applies it,
// waits a settle time, then replies "=" + output bits + "#".
module uart_vector_harness #(
    parameter int unsigned IN_BITS  = 11,
    parameter int unsigned OUT_BITS = 8,
    parameter int unsigned ECHO     = 1,
    parameter int unsigned SETTLE   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_ready,
    input  logic                tx_ready,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic [IN_BITS-1:0]  cut_in,
    input  logic [OUT_BITS-1:0] cut_out,
    output logic                cut_strobe,
    output logic [15:0]         frame_cnt,
    output logic [7:0]          err_cnt
);

    localparam int unsigned IDX_W = $clog2(IN_BITS + 1);
    localparam int unsigned BIT_W = $clog2(OUT_BITS + 1);
    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [3:0] {
        S_RX, S_ECHO_SEND, S_ECHO_BUSY, S_APPLY, S_SETTLE,
        S_EQ_SEND, S_EQ_BUSY, S_BIT_SEND, S_BIT_BUSY,
        S_HASH_SEND, S_HASH_BUSY, S_ERR_SEND, S_ERR_BUSY
    } state_t;

    state_t              state_q;
    logic [IN_BITS-1:0]  shreg_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IN_BITS-1:0]  cut_in_q;
    logic                cut_strobe_q;
    logic                tx_start_q;
    logic [7:0]          tx_data_q;
    logic [15:0]         frame_cnt_q;
    logic [7:0]          err_cnt_q;
    logic                hold_full_q;
    logic [7:0]          hold_data_q;
    logic [SET_W-1:0]    settle_q;
    logic [OUT_BITS-1:0] cap_q;
    logic [BIT_W-1:0]    bit_cnt_q;

    logic       have_byte_c;
    logic [7:0] cur_byte_c;
    logic       is_bit_c;
    logic       is_ws_c;
    logic       drop_c;
    logic       err_tx_c;
    logic [8:0] err_sum_c;
    logic [7:0] err_d;

    // Byte seen by RX this cycle: the held byte takes priority over a live strobe
    always_comb begin
        have_byte_c = 1'b0;
        cur_byte_c  = 8'h00;
        if (state_q == S_RX) begin
            if (hold_full_q) begin
                have_byte_c = 1'b1;
                cur_byte_c  = hold_data_q;
            end else begin
                have_byte_c = rx_ready;
                cur_byte_c  = rx_data;
            end
        end
        is_bit_c  = (cur_byte_c == 8'h30) || (cur_byte_c == 8'h31);
        is_ws_c   = (cur_byte_c == 8'h20) || (cur_byte_c == 8'h0D) || (cur_byte_c == 8'h0A);
        drop_c    = rx_ready && hold_full_q && (state_q != S_RX);
        err_tx_c  = (state_q == S_ERR_SEND) && tx_ready;
        err_sum_c = {1'b0, err_cnt_q} + 9'(drop_c) + 9'(err_tx_c);
        err_d     = err_sum_c[8] ? 8'hFF : err_sum_c[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RX;
            shreg_q      <= '0;
            idx_q        <= '0;
            cut_in_q     <= '0;
            cut_strobe_q <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            frame_cnt_q  <= 16'h0000;
            err_cnt_q    <= 8'h00;
            hold_full_q  <= 1'b0;
            hold_data_q  <= 8'h00;
            settle_q     <= '0;
            cap_q        <= '0;
            bit_cnt_q    <= '0;
        end else begin
            tx_start_q   <= 1'b0;
            cut_strobe_q <= 1'b0;
            err_cnt_q    <= err_d;

            // One-entry hold buffer; in RX a live byte refills it as the held one is consumed
            if (state_q == S_RX) begin
                if (hold_full_q) begin
                    hold_full_q <= rx_ready;
                    if (rx_ready) hold_data_q <= rx_data;
                end
            end else if (rx_ready && !hold_full_q) begin
                hold_full_q <= 1'b1;
                hold_data_q <= rx_data;
            end

            case (state_q)
                S_RX: begin
                    if (have_byte_c) begin
                        if (is_bit_c) begin
                            shreg_q <= (shreg_q << 1) | IN_BITS'(cur_byte_c[0]);
                            idx_q   <= idx_q + IDX_W'(1);
                            if (ECHO != 0) begin
                                tx_data_q <= cur_byte_c;
                                state_q   <= S_ECHO_SEND;
                            end else if (idx_q == IDX_W'(IN_BITS - 1)) begin
                                state_q <= S_APPLY;
                            end
                        end else if (!is_ws_c) begin
                            idx_q   <= '0;
                            shreg_q <= '0;
                            state_q <= S_ERR_SEND;
                        end
                    end
                end
                S_ECHO_SEND: if (tx_ready) begin
                    tx_start_q <= 1'b1;
                    state_q    <= S_ECHO_BUSY;
                end
                S_ECHO_BUSY: if (!tx_ready) begin
                    state_q <= (idx_q == IDX_W'(IN_BITS)) ? S_APPLY : S_RX;
                end
                S_APPLY: begin
                    cut_in_q     <= shreg_q;
                    cut_strobe_q <= 1'b1;
                    idx_q        <= '0;
                    settle_q     <= SET_W'(SETTLE - 1);
                    state_q      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == '0) begin
                        cap_q     <= cut_out;
                        bit_cnt_q <= '0;
                        state_q   <= S_EQ_SEND;
                    end else begin
                        settle_q <= settle_q - SET_W'(1);
                    end
                end
                S_EQ_SEND: if (tx_ready) begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= 8'h3D;
                    state_q    <= S_EQ_BUSY;
                end
                S_EQ_BUSY: if (!tx_ready) state_q <= S_BIT_SEND;
                S_BIT_SEND: if (tx_ready) begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= cap_q[OUT_BITS-1] ? 8'h31 : 8'h30;
                    state_q    <= S_BIT_BUSY;
                end
                S_BIT_BUSY: if (!tx_ready) begin
                    cap_q <= cap_q << 1;
                    if (bit_cnt_q == BIT_W'(OUT_BITS - 1)) begin
                        state_q <= S_HASH_SEND;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        state_q   <= S_BIT_SEND;
                    end
                end
                S_HASH_SEND: if (tx_ready) begin
                    tx_start_q  <= 1'b1;
                    tx_data_q   <= 8'h23;
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                    state_q     <= S_HASH_BUSY;
                end
                S_HASH_BUSY: if (!tx_ready) state_q <= S_RX;
                S_ERR_SEND: if (tx_ready) begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= 8'h3F;
                    state_q    <= S_ERR_BUSY;
                end
                S_ERR_BUSY: if (!tx_ready) state_q <= S_RX;
                default: state_q <= S_RX;
            endcase
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign cut_in     = cut_in_q;
    assign cut_strobe = cut_strobe_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule
